// File: rtl/nes_cpu_mem.sv
// CPU-side memory map for the 6502 core: mirrored work RAM, loader-filled PRG ROM,
// open-bus reads on unmapped addresses, and a valid/rdy handshake with ROM wait states.
module nes_cpu_mem #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter int                RAM_AW      = 11,
    parameter logic [ADDR_W-1:0] RAM_LIMIT   = 16'h2000,
    parameter logic [ADDR_W-1:0] ROM_BASE    = 16'h8000,
    parameter int                ROM_AW      = 15,
    parameter int                WAIT_STATES = 1,
    parameter int                VCNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              rw_n,
    output logic [DATA_W-1:0] dout,
    output logic              rdy,
    input  logic              load_en,
    input  logic [ROM_AW-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [VCNT_W-1:0] viol_cnt
);

    localparam int RAM_DEPTH = 1 << RAM_AW;
    localparam int ROM_DEPTH = 1 << ROM_AW;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    logic [DATA_W-1:0] ram_mem [RAM_DEPTH];
    logic [DATA_W-1:0] rom_mem [ROM_DEPTH];

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] hold_reg, hold_next;
    logic [DATA_W-1:0] dout_reg, dout_next;
    logic [DATA_W-1:0] open_bus_reg, open_bus_next;
    logic [VCNT_W-1:0] viol_reg, viol_next;

    logic              is_ram;
    logic              is_rom;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rd;
    logic [DATA_W-1:0] rom_rd;
    logic [DATA_W-1:0] rd_val;

    assign is_ram = (addr < RAM_LIMIT);
    assign is_rom = (addr >= ROM_BASE);
    assign ram_rd = ram_mem[addr[RAM_AW-1:0]];
    assign rom_rd = rom_mem[addr[ROM_AW-1:0]];
    assign rd_val = is_ram ? ram_rd : (is_rom ? rom_rd : open_bus_reg);

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        hold_next     = hold_reg;
        dout_next     = dout_reg;
        open_bus_next = open_bus_reg;
        viol_next     = viol_reg;
        ram_we        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (valid) begin
                    if (!rw_n) begin
                        state_next    = DONE;
                        open_bus_next = din;
                        if (is_ram) begin
                            ram_we = 1'b1;
                        end else if (is_rom && (viol_reg != {VCNT_W{1'b1}})) begin
                            viol_next = viol_reg + 1'b1;
                        end
                    end else if (is_rom && (WAIT_STATES != 0)) begin
                        // ROM data is sampled now and parked until the wait expires
                        hold_next  = rd_val;
                        cnt_next   = CNT_W'(WAIT_STATES);
                        state_next = WAIT;
                    end else begin
                        dout_next     = rd_val;
                        open_bus_next = rd_val;
                        state_next    = DONE;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == CNT_W'(1)) begin
                    dout_next     = hold_reg;
                    open_bus_next = hold_reg;
                    state_next    = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            hold_reg     <= '0;
            dout_reg     <= '0;
            open_bus_reg <= '0;
            viol_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            hold_reg     <= hold_next;
            dout_reg     <= dout_next;
            open_bus_reg <= open_bus_next;
            viol_reg     <= viol_next;
        end
    end

    // Memory contents survive reset; only the CPU write is suppressed by it
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            ram_mem[addr[RAM_AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (load_en) begin
            rom_mem[load_addr] <= load_data;
        end
    end

    assign dout     = dout_reg;
    assign rdy      = (state_reg == DONE);
    assign viol_cnt = viol_reg;

endmodule

// File: tb/tb_nes_cpu_mem.sv
// Scoreboard bench for nes_cpu_mem: three instances with 0, 2 and 3 ROM wait states.
module tb_nes_cpu_mem;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst       [N];
    logic        valid     [N];
    logic [15:0] addr      [N];
    logic [7:0]  din       [N];
    logic        rw_n      [N];
    logic [7:0]  dout      [N];
    logic        rdy       [N];
    logic        load_en   [N];
    logic [14:0] load_addr [N];
    logic [7:0]  load_data [N];
    logic [7:0]  viol_cnt  [N];

    typedef struct {
        logic [7:0] dout;
        int         lat;
        int         acc;
    } exp_t;

    exp_t exp_q [N][$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            nes_cpu_mem #(
                .WAIT_STATES((gi == 0) ? 0 : ((gi == 1) ? 2 : 3))
            ) u_dut (
                .clk      (clk),
                .rst      (rst[gi]),
                .valid    (valid[gi]),
                .addr     (addr[gi]),
                .din      (din[gi]),
                .rw_n     (rw_n[gi]),
                .dout     (dout[gi]),
                .rdy      (rdy[gi]),
                .load_en  (load_en[gi]),
                .load_addr(load_addr[gi]),
                .load_data(load_data[gi]),
                .viol_cnt (viol_cnt[gi])
            );
        end
    endgenerate

    function automatic void check(string nm, int act, int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endfunction

    // Monitor: every rdy pulse pops one expectation and checks data and latency
    generate
        for (gi = 0; gi < N; gi++) begin : g_mon
            exp_t mon_e;
            always @(negedge clk) begin
                if (rdy[gi] === 1'b1) begin
                    if (exp_q[gi].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rdy dut%0d: got rdy=1 dout=%0h, expected no rdy", gi, dout[gi]);
                    end else begin
                        mon_e = exp_q[gi].pop_front();
                        check($sformatf("dut%0d_dout", gi), int'(dout[gi]), int'(mon_e.dout));
                        check($sformatf("dut%0d_latency", gi), cyc - mon_e.acc, mon_e.lat);
                        $display("dut%0d txn: dout=%0h latency=%0d", gi, dout[gi], cyc - mon_e.acc);
                    end
                end
            end
        end
    endgenerate

    task automatic bus(input int d, input logic rw, input logic [15:0] a, input logic [7:0] wd,
                       input logic [7:0] exp_d, input int exp_lat,
                       input logic ld = 1'b0, input logic [14:0] la = '0, input logic [7:0] ldat = '0);
        exp_t e;
        bit   got;
        @(negedge clk);
        e.dout = exp_d;
        e.lat  = exp_lat;
        e.acc  = cyc;
        exp_q[d].push_back(e);
        valid[d] = 1'b1; addr[d] = a; din[d] = wd; rw_n[d] = rw;
        load_en[d] = ld; load_addr[d] = la; load_data[d] = ldat;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            load_en[d] = 1'b0;
            if (rdy[d] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        valid[d] = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL bus_timeout dut%0d addr=%0h: got no rdy, expected rdy within 20 cycles", d, a);
            void'(exp_q[d].pop_front());
        end
    endtask

    task automatic load(input int d, input logic [14:0] la, input logic [7:0] v);
        @(negedge clk);
        load_en[d] = 1'b1; load_addr[d] = la; load_data[d] = v;
        @(negedge clk);
        load_en[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1; valid[i] = 1'b0; addr[i] = '0; din[i] = '0; rw_n[i] = 1'b1;
            load_en[i] = 1'b0; load_addr[i] = '0; load_data[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("reset_dout%0d", i), int'(dout[i]), 0);
            check($sformatf("reset_rdy%0d", i), int'(rdy[i]), 0);
            check($sformatf("reset_viol%0d", i), int'(viol_cnt[i]), 0);
            rst[i] = 1'b0;
        end

        // Instance 1 (two wait states): mirror, ROM wait, write protect, open bus
        bus(1, 1'b0, 16'h0005, 8'hA5, 8'h00, 1);
        bus(1, 1'b1, 16'h0805, 8'h00, 8'hA5, 1);
        bus(1, 1'b1, 16'h1805, 8'h00, 8'hA5, 1);
        load(1, 15'h0000, 8'h4C);
        bus(1, 1'b1, 16'h8000, 8'h00, 8'h4C, 3);
        bus(1, 1'b0, 16'h8000, 8'h00, 8'h4C, 1);
        @(negedge clk);
        check("viol_after_one", int'(viol_cnt[1]), 1);
        bus(1, 1'b1, 16'h8000, 8'h00, 8'h4C, 3);
        bus(1, 1'b1, 16'h0005, 8'h00, 8'hA5, 1);
        bus(1, 1'b1, 16'h4020, 8'h00, 8'hA5, 1);
        bus(1, 1'b0, 16'h4020, 8'h3C, 8'hA5, 1);
        bus(1, 1'b1, 16'h5000, 8'h00, 8'h3C, 1);
        @(negedge clk);
        check("viol_unmapped_write", int'(viol_cnt[1]), 1);
        for (int i = 0; i < 299; i++) bus(1, 1'b0, 16'h8000, 8'h00, 8'h3C, 1);
        @(negedge clk);
        check("viol_saturated", int'(viol_cnt[1]), 255);
        bus(1, 1'b1, 16'h6000, 8'h00, 8'h00, 1);

        // Instance 0 (no wait states): ROM latency and loader collision
        load(0, 15'h0000, 8'h4C);
        bus(0, 1'b1, 16'h8000, 8'h00, 8'h4C, 1);
        load(0, 15'h0010, 8'h11);
        bus(0, 1'b1, 16'h8010, 8'h00, 8'h11, 1, 1'b1, 15'h0010, 8'h22);
        bus(0, 1'b1, 16'h8010, 8'h00, 8'h22, 1);

        // Instance 2 (three wait states): boundaries and reset mid-cycle
        bus(2, 1'b0, 16'h07FF, 8'h5A, 8'h00, 1);
        bus(2, 1'b1, 16'h1FFF, 8'h00, 8'h5A, 1);
        load(2, 15'h7FFF, 8'h99);
        bus(2, 1'b1, 16'hFFFF, 8'h00, 8'h99, 4);
        bus(2, 1'b1, 16'h7FFF, 8'h00, 8'h99, 1);
        bus(2, 1'b0, 16'h0100, 8'h11, 8'h99, 1);

        @(negedge clk);
        valid[2] = 1'b1; addr[2] = 16'h0100; din[2] = 8'h77; rw_n[2] = 1'b0; rst[2] = 1'b1;
        @(negedge clk);
        valid[2] = 1'b0; rst[2] = 1'b0;
        check("rst_on_write_rdy", int'(rdy[2]), 0);
        check("rst_on_write_dout", int'(dout[2]), 0);
        bus(2, 1'b1, 16'h0100, 8'h00, 8'h11, 1);

        @(negedge clk);
        valid[2] = 1'b1; addr[2] = 16'h8000; rw_n[2] = 1'b1;
        @(negedge clk);
        check("wait1_rdy", int'(rdy[2]), 0);
        @(negedge clk);
        rst[2] = 1'b1; valid[2] = 1'b0;
        @(negedge clk);
        rst[2] = 1'b0;
        check("rst_wait_rdy", int'(rdy[2]), 0);
        check("rst_wait_dout", int'(dout[2]), 0);
        repeat (6) @(negedge clk);
        check("rst_wait_no_late_rdy", int'(rdy[2]), 0);
        bus(2, 1'b1, 16'h0FFF, 8'h00, 8'h5A, 1);

        repeat (4) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("queue_empty%0d", i), exp_q[i].size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
